fetch_pc: RTL

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc_pkg.sv | 14 +
 rtl/fetch_pc.sv | 85 ++++++++
 2 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared fetch-path parameters: address/word widths, branch-epoch tag width,
// and the word-alignment helper used on redirect targets.
package fetch_pc_pkg;

  localparam int ADDR   = 32;
  localparam int WORD   = 32;
  localparam int W_BRID = 4;

  // Redirect targets are forced onto a word boundary by dropping the byte offset.
  function automatic logic [ADDR-1:0] alignWord(input logic [ADDR-1:0] addr);
    return {addr[ADDR-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch stage: boots for one cycle, free-runs by one word,
// honours stall/halt, and takes execute-stage redirects with a new branch epoch.
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              br_v_i,
  input  logic [ADDR-1:0]   br_pc_i,
  output logic [ADDR-1:0]   pc_o,
  output logic              req_o,
  output logic [W_BRID-1:0] brid_o,
  output logic              branch_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR-1:0] PC_STEP = ADDR'(4);

  state_t            state_q, state_d;
  logic [ADDR-1:0]   pc_q, pc_d;
  logic [W_BRID-1:0] brid_q, brid_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      brid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      brid_q  <= brid_d;
    end
  end

  // A redirect beats stall and halt; a stall holds the PC even when halt is also raised.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    brid_d   = brid_q;
    req_o    = 1'b0;
    branch_o = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        req_o    = 1'b1;
        branch_o = br_v_i;
        if (br_v_i) begin
          pc_d   = alignWord(br_pc_i);
          brid_d = brid_q + W_BRID'(1);
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (halt_i) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
      end
      HALT: begin
        if (br_v_i) begin
          state_d = RUN;
          pc_d    = alignWord(br_pc_i);
          brid_d  = brid_q + W_BRID'(1);
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pc_o   = pc_q;
  assign brid_o = brid_q;

endmodule
